rc4_prga_decrypt: RTL and testbench
===================================

// Module: rc4_prga_decrypt
// PURPOSE
//  Reads the permuted S array that the key-schedule stage leaves in the shared S RAM, and runs the RC4 PRGA on it.
//  XORs each keystream byte with the encrypted message ROM and writes the plaintext to the decrypted-message RAM.
//  Flags the message as invalid on the first byte that is not lowercase ASCII or space, so a key-search controller can abort.
//  Sits after the key schedule in the decrypt chain; the S RAM must already hold the permuted array when start is applied.
// PARAMETERS
//  MSG_LEN  32  number of message bytes to decrypt (1..2**MSG_AW)
//  MSG_AW   5   address width of the message ROM and RAM
// PORTS
//  clk          in   1       single clock; all logic on posedge
//  reset        in   1       synchronous, active-high
//  start        in   1       begin decryption; sampled in IDLE and DONE only
//  s_address    out  8       S RAM address
//  s_data       out  8       S RAM write data
//  s_wren       out  1       S RAM write enable
//  s_q          in   8       S RAM read data; 1-cycle synchronous read
//  rom_address  out  MSG_AW  encrypted message ROM address
//  rom_q        in   8       encrypted byte; 1-cycle synchronous read
//  ram_address  out  MSG_AW  decrypted message RAM address
//  ram_data     out  8       decrypted byte
//  ram_wren     out  1       decrypted RAM write enable
//  busy         out  1       high from the cycle after start is accepted until DONE is entered
//  done         out  1       level; high in DONE
//  fail         out  1       level; high in DONE when an invalid byte was found
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset (any cycle, including mid-message): every output goes to 0, i = j = k = 0, state = IDLE. No write completes after the reset edge.
//  - i and j are 8-bit and wrap modulo 256. k is MSG_AW bits. s_address for f is (si + sj)[7:0].
//  - Each write state drives its wren for exactly one cycle, with address and data valid in that same cycle. wren is 0 in every other state.
//  - Reads: the FSM presents the address in RD_x, waits in WAIT_x, and samples q in LATCH_x.
//  - FSM, one cycle per state:
//    IDLE     : if start, clear i, j, k, fail; go to INC_I.
//    INC_I    : i <= i + 1.
//    RD_SI    : s_address <= i.
//    WAIT_SI  : no action.
//    LATCH_SI : si <= s_q; j <= j + s_q.
//    RD_SJ    : s_address <= j.
//    WAIT_SJ  : no action.
//    LATCH_SJ : sj <= s_q.
//    WR_SJ    : s_address <= j; s_data <= si; s_wren = 1.
//    WR_SI    : s_address <= i; s_data <= sj; s_wren = 1.
//    RD_F     : s_address <= si + sj; rom_address <= k.
//    WAIT_F   : no action.
//    LATCH_F  : f <= s_q; enc <= rom_q.
//    WR_OUT   : ram_address <= k; ram_data <= f ^ enc; ram_wren = 1.
//               Byte is valid iff it is 8'h20 or lies in 8'h61..8'h7A.
//    NEXT     : if the byte was invalid, set fail and go to DONE.
//               Else if k == MSG_LEN-1, go to DONE.
//               Else k <= k + 1 and go to INC_I.
//    DONE     : done = 1 and busy = 0. If start, clear done and fail and restart as in IDLE.
//  - Latency: 14 cycles per byte. With no failure, done is high after edge 14*MSG_LEN + 1, counted from the edge that samples start.
//  - Case i == j: both writes go to the same address with equal data. S is unchanged, which is legal RC4.
//  - An invalid byte is still written to the RAM before the FSM aborts, so a failed run leaves k+1 bytes written.
//  - start is ignored while busy. The block never re-initialises S; restarting requires S to be reloaded externally.
// TESTING
//  1. Preload S[n] = n and ROM = 63,67,64; set MSG_LEN = 3; pulse start.
//     Required: keystream 02,05,07 and RAM = 61,62,63 ("abc"); done = 1, fail = 0.
//     Required: S[1]=01, S[2]=03, S[3]=05, S[5]=02.
//  2. Same setup but ROM[1] = 00.
//     Required: RAM[1] = 05, exactly 2 ram_wren pulses, done = 1, fail = 1.
//  3. Measure latency in test 1.
//     Required: done rises at edge 43 after start. s_wren pulses exactly 6 times and ram_wren exactly 3 times, each one cycle wide.
//  4. Assert reset 20 cycles into test 1.
//     Required: all outputs 0 on the next edge, no further writes, FSM in IDLE. A new start then reproduces test 1 from a freshly loaded S.
//  5. Pulse start again while busy: no effect. After done, pulse start with S reloaded: done clears and the run repeats identically.
//  6. After a key schedule with key 24'h000249 and MSG_LEN = 32: RAM contents match the software RC4 model byte for byte.

Source files
------------

// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generator and decryptor: runs the PRGA over the permuted S RAM,
// XORs the keystream with the encrypted ROM and writes plaintext, aborting on non-text bytes.
//
// state    | meaning
// IDLE     | waiting for start
// INC_I    | advance i
// RD_SI    | present S[i] address
// WAIT_SI  | S RAM read latency
// LATCH_SI | capture si, accumulate j
// RD_SJ    | present S[j] address
// WAIT_SJ  | S RAM read latency
// LATCH_SJ | capture sj
// WR_SJ    | write S[j] = si
// WR_SI    | write S[i] = sj
// RD_F     | present S[si+sj] and ROM[k] addresses
// WAIT_F   | S RAM / ROM read latency
// LATCH_F  | capture keystream and encrypted byte
// WR_OUT   | write decrypted byte
// NEXT     | abort, finish or advance k
// DONE     | finished; done high, fail reports an invalid byte
module rc4_prga_decrypt #(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [7:0]        s_address,
    output logic [7:0]        s_data,
    output logic              s_wren,
    input  logic [7:0]        s_q,
    output logic [MSG_AW-1:0] rom_address,
    input  logic [7:0]        rom_q,
    output logic [MSG_AW-1:0] ram_address,
    output logic [7:0]        ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done,
    output logic              fail
);

    typedef enum logic [3:0] {
        IDLE, INC_I, RD_SI, WAIT_SI, LATCH_SI, RD_SJ, WAIT_SJ, LATCH_SJ,
        WR_SJ, WR_SI, RD_F, WAIT_F, LATCH_F, WR_OUT, NEXT, DONE
    } state_t;

    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

    state_t            state, state_nxt;
    logic [7:0]        i, j, si, sj;
    logic [MSG_AW-1:0] k;
    logic              byte_ok;

    assign byte_ok = (ram_data == 8'h20) || ((ram_data >= 8'h61) && (ram_data <= 8'h7A));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = INC_I;
            INC_I:    state_nxt = RD_SI;
            RD_SI:    state_nxt = WAIT_SI;
            WAIT_SI:  state_nxt = LATCH_SI;
            LATCH_SI: state_nxt = RD_SJ;
            RD_SJ:    state_nxt = WAIT_SJ;
            WAIT_SJ:  state_nxt = LATCH_SJ;
            LATCH_SJ: state_nxt = WR_SJ;
            WR_SJ:    state_nxt = WR_SI;
            WR_SI:    state_nxt = RD_F;
            RD_F:     state_nxt = WAIT_F;
            WAIT_F:   state_nxt = LATCH_F;
            LATCH_F:  state_nxt = WR_OUT;
            WR_OUT:   state_nxt = NEXT;
            NEXT:     state_nxt = (!byte_ok || (k == K_LAST)) ? DONE : INC_I;
            DONE:     if (start) state_nxt = INC_I;
            default:  state_nxt = IDLE;
        endcase
    end

    // Write address/data are loaded on entry to the write state so they line up with wren.
    always_ff @(posedge clk) begin
        if (reset) begin
            i           <= '0;
            j           <= '0;
            k           <= '0;
            si          <= '0;
            sj          <= '0;
            s_address   <= '0;
            s_data      <= '0;
            s_wren      <= 1'b0;
            rom_address <= '0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
        end else begin
            s_wren   <= (state_nxt == WR_SJ) || (state_nxt == WR_SI);
            ram_wren <= (state_nxt == WR_OUT);
            done     <= (state == DONE) && !start;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        i    <= '0;
                        j    <= '0;
                        k    <= '0;
                        fail <= 1'b0;
                        busy <= 1'b1;
                    end
                end
                INC_I:    i <= i + 8'd1;
                RD_SI:    s_address <= i;
                LATCH_SI: begin
                    si <= s_q;
                    j  <= j + s_q;
                end
                RD_SJ:    s_address <= j;
                LATCH_SJ: begin
                    sj        <= s_q;
                    s_address <= j;
                    s_data    <= si;
                end
                WR_SJ: begin
                    s_address <= i;
                    s_data    <= sj;
                end
                RD_F: begin
                    s_address   <= si + sj;
                    rom_address <= k;
                end
                LATCH_F: begin
                    ram_address <= k;
                    ram_data    <= s_q ^ rom_q;
                end
                NEXT: begin
                    if (!byte_ok) begin
                        fail <= 1'b1;
                        busy <= 1'b0;
                    end else if (k == K_LAST) begin
                        busy <= 1'b0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt: a 3-byte instance for the directed cases and a
// 32-byte instance checked against a software RC4 model.
module tb_rc4_prga_decrypt;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       start    [2];
    logic       s_wren   [2];
    logic       ram_wren [2];
    logic       busy     [2];
    logic       done     [2];
    logic       fail     [2];
    logic       s_load   [2];
    logic [7:0] s_address [2];
    logic [7:0] s_data    [2];
    logic [7:0] s_q       [2];
    logic [7:0] rom_q     [2];
    logic [7:0] ram_data  [2];
    logic [4:0] rom_address [2];
    logic [4:0] ram_address [2];

    logic [7:0] s_mem  [2][256];
    logic [7:0] s_init [2][256];
    logic [7:0] rom    [2][32];
    logic [7:0] ram    [2][32];
    int         swr_cnt [2];
    int         rwr_cnt [2];

    int checks   = 0;
    int failures = 0;

    logic [7:0] sw [256];
    logic [7:0] key [3];
    logic [7:0] i8, j8, t8, ks;
    int         n;
    string      pt = "the quick brown fox jumps over x";

    rc4_prga_decrypt #(.MSG_LEN(3), .MSG_AW(5)) dut_a (
        .clk(clk), .reset(reset), .start(start[0]),
        .s_address(s_address[0]), .s_data(s_data[0]), .s_wren(s_wren[0]), .s_q(s_q[0]),
        .rom_address(rom_address[0]), .rom_q(rom_q[0]),
        .ram_address(ram_address[0]), .ram_data(ram_data[0]), .ram_wren(ram_wren[0]),
        .busy(busy[0]), .done(done[0]), .fail(fail[0])
    );

    rc4_prga_decrypt #(.MSG_LEN(32), .MSG_AW(5)) dut_b (
        .clk(clk), .reset(reset), .start(start[1]),
        .s_address(s_address[1]), .s_data(s_data[1]), .s_wren(s_wren[1]), .s_q(s_q[1]),
        .rom_address(rom_address[1]), .rom_q(rom_q[1]),
        .ram_address(ram_address[1]), .ram_data(ram_data[1]), .ram_wren(ram_wren[1]),
        .busy(busy[1]), .done(done[1]), .fail(fail[1])
    );

    // Memory models: synchronous-read S RAM and ROM, write-only plaintext RAM.
    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            s_q[c]   <= s_mem[c][s_address[c]];
            rom_q[c] <= rom[c][rom_address[c]];
            if (s_load[c]) begin
                for (int a = 0; a < 256; a++) s_mem[c][a] <= s_init[c][a];
                for (int a = 0; a < 32; a++)  ram[c][a]   <= 8'h00;
                swr_cnt[c] <= 0;
                rwr_cnt[c] <= 0;
            end else begin
                if (s_wren[c]) begin
                    s_mem[c][s_address[c]] <= s_data[c];
                    swr_cnt[c] <= swr_cnt[c] + 1;
                end
                if (ram_wren[c]) begin
                    ram[c][ram_address[c]] <= ram_data[c];
                    rwr_cnt[c] <= rwr_cnt[c] + 1;
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load_s(input int c);
        s_load[c] = 1'b1;
        @(posedge clk); #1;
        s_load[c] = 1'b0;
    endtask

    task automatic prep_a(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        for (int a = 0; a < 256; a++) s_init[0][a] = 8'(a);
        rom[0][0] = e0;
        rom[0][1] = e1;
        rom[0][2] = e2;
        load_s(0);
    endtask

    task automatic start_pulse(input int c);
        start[c] = 1'b1;
        @(posedge clk); #1;
        start[c] = 1'b0;
    endtask

    task automatic wait_done(input int c, input int n0, output int cnt);
        cnt = n0;
        while (!done[c] && cnt < 3000) begin
            @(posedge clk); #1;
            cnt++;
        end
    endtask

    task automatic check_abc(input string tag);
        check_val({tag, "_ram0"}, ram[0][0], 8'h61);
        check_val({tag, "_ram1"}, ram[0][1], 8'h62);
        check_val({tag, "_ram2"}, ram[0][2], 8'h63);
        check_val({tag, "_done"}, done[0], 1'b1);
        check_val({tag, "_fail"}, fail[0], 1'b0);
        check_val({tag, "_busy"}, busy[0], 1'b0);
        check_val({tag, "_s1"}, s_mem[0][1], 8'h01);
        check_val({tag, "_s2"}, s_mem[0][2], 8'h03);
        check_val({tag, "_s3"}, s_mem[0][3], 8'h05);
        check_val({tag, "_s5"}, s_mem[0][5], 8'h02);
        check_val({tag, "_swr"}, swr_cnt[0], 6);
        check_val({tag, "_rwr"}, rwr_cnt[0], 3);
    endtask

    int lat;

    initial begin
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            start[c]  = 1'b0;
            s_load[c] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_outs", |{s_address[0], s_data[0], s_wren[0], rom_address[0],
                  ram_address[0], ram_data[0], ram_wren[0], busy[0], done[0], fail[0]}, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Identity S, ciphertext of "abc"; also latency and pulse counts
        prep_a(8'h63, 8'h67, 8'h64);
        start_pulse(0);
        check_val("t1_busy_run", busy[0], 1'b1);
        wait_done(0, 0, lat);
        check_val("t1_latency", lat, 43);
        check_abc("t1");

        // Invalid second byte aborts after writing it
        prep_a(8'h63, 8'h00, 8'h64);
        start_pulse(0);
        wait_done(0, 0, lat);
        check_val("t2_latency", lat, 29);
        check_val("t2_ram0", ram[0][0], 8'h61);
        check_val("t2_ram1", ram[0][1], 8'h05);
        check_val("t2_ram2", ram[0][2], 8'h00);
        check_val("t2_rwr", rwr_cnt[0], 2);
        check_val("t2_done", done[0], 1'b1);
        check_val("t2_fail", fail[0], 1'b1);

        // Reset 20 cycles into a run
        prep_a(8'h63, 8'h67, 8'h64);
        start_pulse(0);
        repeat (19) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        check_val("t4_outs_zero", |{s_address[0], s_data[0], s_wren[0], rom_address[0],
                  ram_address[0], ram_data[0], ram_wren[0], busy[0], done[0], fail[0]}, 1'b0);
        check_val("t4_swr_at_rst", swr_cnt[0], 2);
        check_val("t4_rwr_at_rst", rwr_cnt[0], 1);
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_val("t4_swr_hold", swr_cnt[0], 2);
        check_val("t4_rwr_hold", rwr_cnt[0], 1);
        check_val("t4_idle", {busy[0], done[0], s_wren[0]}, 3'b000);
        prep_a(8'h63, 8'h67, 8'h64);
        start_pulse(0);
        wait_done(0, 0, lat);
        check_val("t4_latency", lat, 43);
        check_abc("t4");

        // start while busy is ignored; restart from DONE repeats the run
        prep_a(8'h63, 8'h67, 8'h64);
        start_pulse(0);
        repeat (10) begin @(posedge clk); #1; end
        start_pulse(0);
        wait_done(0, 11, lat);
        check_val("t5_latency_busy_start", lat, 43);
        check_abc("t5a");
        prep_a(8'h63, 8'h67, 8'h64);
        check_val("t5_done_before", done[0], 1'b1);
        start_pulse(0);
        check_val("t5_done_cleared", done[0], 1'b0);
        check_val("t5_busy_restart", busy[0], 1'b1);
        wait_done(0, 0, lat);
        check_val("t5_latency_restart", lat, 43);
        check_abc("t5b");

        // 32-byte message after a key schedule with key 000249
        key[0] = 8'h00; key[1] = 8'h02; key[2] = 8'h49;
        for (int a = 0; a < 256; a++) sw[a] = 8'(a);
        j8 = 8'h00;
        for (int a = 0; a < 256; a++) begin
            j8 = j8 + sw[a] + key[a % 3];
            t8 = sw[a]; sw[a] = sw[j8]; sw[j8] = t8;
        end
        for (int a = 0; a < 256; a++) s_init[1][a] = sw[a];
        i8 = 8'h00; j8 = 8'h00;
        for (int m = 0; m < 32; m++) begin
            i8 = i8 + 8'd1;
            j8 = j8 + sw[i8];
            t8 = sw[i8]; sw[i8] = sw[j8]; sw[j8] = t8;
            t8 = sw[i8] + sw[j8];
            ks = sw[t8];
            rom[1][m] = pt[m] ^ ks;
        end
        load_s(1);
        start_pulse(1);
        wait_done(1, 0, lat);
        check_val("t6_latency", lat, 449);
        check_val("t6_done", done[1], 1'b1);
        check_val("t6_fail", fail[1], 1'b0);
        check_val("t6_rwr", rwr_cnt[1], 32);
        check_val("t6_swr", swr_cnt[1], 64);
        n = 0;
        for (int m = 0; m < 32; m++) begin
            if (ram[1][m] !== pt[m]) n++;
            check_val($sformatf("t6_ram%0d", m), ram[1][m], pt[m]);
        end
        for (int a = 0; a < 256; a++)
            if (s_mem[1][a] !== sw[a]) n++;
        check_val("t6_s_final_diffs", n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
